// File: rtl/demux_sched_pkg.sv
// ---------------------------------------------------------------------------
// demux_sched_pkg
// Shared definitions for the 16-way demux round-robin scheduler.
//   N_CH    : number of demux destinations (fixed at 16)
//   SEL_W   : width of the demux select, log2(N_CH)
//   state_t : sequencer states IDLE / SEEK / XFER / NEXT
// ---------------------------------------------------------------------------
package demux_sched_pkg;

  localparam int N_CH  = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    XFER = 2'd2,
    NEXT = 2'd3
  } state_t;

endpackage

// File: rtl/demux_rr_scheduler_next_chan_finder.sv
// ---------------------------------------------------------------------------
// next_chan_finder
// Combinational search for the lowest set mask bit at or above a pointer.
// Ports:
//   i_mask  [15:0] : channels still to be visited in this pass
//   i_ptr   [3:0]  : lowest index eligible for selection
//   o_idx   [3:0]  : index of the lowest set bit >= i_ptr (0 if none)
//   o_found        : high when such a bit exists
// ---------------------------------------------------------------------------
module next_chan_finder
  import demux_sched_pkg::*;
(
  input  logic [N_CH-1:0]  i_mask,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_found
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && (i >= int'(i_ptr))) begin
        o_idx   = SEL_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_rr_scheduler.sv
// ---------------------------------------------------------------------------
// demux_rr_scheduler
// Sequencer for the 16-way 1-bit demux. Each accepted start walks every
// enabled channel in ascending order, drives the demux select and forwards
// BURST_LEN beats per channel under a valid/ready handshake, then pulses
// o_done and bumps o_pass_cnt.
//
// Optional feature macro: DEMUX_SCHED_TIMEOUT_EN
//   defined   : a stall watchdog skips a channel after TIMEOUT beat-less
//               cycles in XFER and sets the sticky o_err flag
//   undefined : no watchdog, o_err stays 0, XFER waits indefinitely
//
// Ports:
//   i_clk, i_rst       : clock, asynchronous active-high reset
//   i_start            : pass request pulse (ignored while busy)
//   i_chan_en [15:0]   : channel enable mask, captured on accepted start
//   i_in_valid/i_in_data, o_in_ready : source beat handshake
//   i_dest_ready[15:0] : per-destination backpressure
//   o_sel [3:0]        : registered demux select
//   o_d_out, o_d_valid : beat data / strobe toward the demux
//   o_busy, o_done     : activity flag, end-of-pass pulse
//   o_pass_cnt         : completed pass counter (wrapping)
//   o_err              : sticky stall-timeout flag
// ---------------------------------------------------------------------------
module demux_rr_scheduler
  import demux_sched_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 8,
  parameter int TIMEOUT   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [N_CH-1:0]  i_chan_en,
  input  logic             i_in_valid,
  input  logic             i_in_data,
  output logic             o_in_ready,
  input  logic [N_CH-1:0]  i_dest_ready,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_d_out,
  output logic             o_d_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_pass_cnt,
  output logic             o_err
);

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  state_t           r_state;
  logic [N_CH-1:0]  r_mask;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] r_sel;
  logic [7:0]       r_beat_cnt;
  logic             r_done;
  logic [CNT_W-1:0] r_pass_cnt;
  logic             r_err;

  logic [SEL_W-1:0] w_idx;
  logic             w_found;
  logic             w_xfer;
  logic             w_dest_rdy;
  logic             w_beat;
  logic             w_last_beat;
  logic             w_timeout;
  logic [N_CH-1:0]  w_mask_left;

  next_chan_finder u_finder (
    .i_mask  (r_mask),
    .i_ptr   (r_ptr),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  // Zero-latency pass-through: the handshake is only open in XFER.
  assign w_xfer      = (r_state == XFER);
  assign w_dest_rdy  = i_dest_ready[r_sel];
  assign w_beat      = w_xfer && i_in_valid && w_dest_rdy;
  assign w_last_beat = w_beat && (r_beat_cnt == LAST_BEAT);

  assign o_in_ready  = w_xfer && w_dest_rdy;
  assign o_d_valid   = w_beat;
  assign o_d_out     = w_beat && i_in_data;
  assign o_sel       = r_sel;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;
  assign o_pass_cnt  = r_pass_cnt;
  assign o_err       = r_err;

  // Mask with the channel just served removed.
  always_comb begin
    w_mask_left        = r_mask;
    w_mask_left[r_sel] = 1'b0;
  end

`ifdef DEMUX_SCHED_TIMEOUT_EN
  localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT - 1);
  logic [15:0] r_stall;

  // Counts consecutive beat-less XFER cycles; the cycle that would make
  // TIMEOUT stalled cycles forces the channel to be abandoned.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall <= '0;
    end else if (!w_xfer || w_beat) begin
      r_stall <= '0;
    end else begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign w_timeout = w_xfer && !w_beat && (r_stall == STALL_LIMIT);
`else
  assign w_timeout = 1'b0;
`endif

  // Main sequencer. o_done is registered so it rises as state returns to
  // IDLE; a SEEK without a match cannot happen but falls back to IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_mask     <= '0;
      r_ptr      <= '0;
      r_sel      <= '0;
      r_beat_cnt <= '0;
      r_done     <= 1'b0;
      r_pass_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_err <= 1'b0;
            if (i_chan_en != '0) begin
              r_mask  <= i_chan_en;
              r_ptr   <= '0;
              r_state <= SEEK;
            end else begin
              r_done     <= 1'b1;
              r_pass_cnt <= r_pass_cnt + CNT_W'(1);
            end
          end
        end
        SEEK: begin
          if (w_found) begin
            r_sel      <= w_idx;
            r_beat_cnt <= '0;
            r_state    <= XFER;
          end else begin
            r_state <= IDLE;
          end
        end
        XFER: begin
          if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
          end
          if (w_last_beat) begin
            r_state <= NEXT;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= NEXT;
          end
        end
        NEXT: begin
          r_mask <= w_mask_left;
          r_ptr  <= r_sel + SEL_W'(1);
          if (w_mask_left == '0) begin
            r_done     <= 1'b1;
            r_pass_cnt <= r_pass_cnt + CNT_W'(1);
            r_state    <= IDLE;
          end else begin
            r_state <= SEEK;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_rr_scheduler.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_demux_rr_scheduler
// Drives directed and random passes into demux_rr_scheduler and compares
// every output, every cycle, against a queue-based pass model.
// ---------------------------------------------------------------------------
module tb_demux_rr_scheduler;

  localparam int BURST = 4;
  localparam int TMO   = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] chanEn;
  logic        inValid;
  logic        inData;
  logic [15:0] destReady;
  logic        inReady;
  logic [3:0]  sel;
  logic        dOut;
  logic        dValid;
  logic        busy;
  logic        done;
  logic [7:0]  passCnt;
  logic        err;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: channels left in the pass, dead cycles before the
  // next transfer phase, beats still owed to the current channel.
  bit         mActive;
  int         mGap;
  int         mChans[$];
  int         mBeatsLeft;
  int         mStall;
  logic [3:0] mSel;
  logic       mDone;
  logic [7:0] mPassCnt;
  logic       mErr;

  int cycleNum;
  int strobes;
  int doneCycle;
  bit sawDone;
  bit sawErr;

  demux_rr_scheduler #(
    .BURST_LEN (BURST),
    .CNT_W     (8),
    .TIMEOUT   (TMO)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_chan_en    (chanEn),
    .i_in_valid   (inValid),
    .i_in_data    (inData),
    .o_in_ready   (inReady),
    .i_dest_ready (destReady),
    .o_sel        (sel),
    .o_d_out      (dOut),
    .o_d_valid    (dValid),
    .o_busy       (busy),
    .o_done       (done),
    .o_pass_cnt   (passCnt),
    .o_err        (err)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mActive    = 1'b0;
    mGap       = 0;
    mChans.delete();
    mBeatsLeft = 0;
    mStall     = 0;
    mSel       = 4'd0;
    mDone      = 1'b0;
    mPassCnt   = 8'd0;
    mErr       = 1'b0;
  endtask

  task automatic finishChannel();
    void'(mChans.pop_front());
    mGap = (mChans.size() > 0) ? 2 : 1;
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs 1 ns
  // later, then advance the model to the state after the next rising edge.
  task automatic applyStimulus(input bit st, input logic [15:0] en, input bit v,
                               input bit d, input logic [15:0] rdy);
    bit expXfer;
    bit expRdy;
    bit expBeat;
    @(negedge clk);
    start     = st;
    chanEn    = en;
    inValid   = v;
    inData    = d;
    destReady = rdy;
    #1;
    cycleNum++;
    expXfer = mActive && (mGap == 0);
    expRdy  = 1'b0;
    if (expXfer) expRdy = rdy[mChans[0]];
    expBeat = expRdy && v;

    checkOutput("busy",     16'(busy),    16'(mActive));
    checkOutput("sel",      16'(sel),     16'(mSel));
    checkOutput("in_ready", 16'(inReady), 16'(expRdy));
    checkOutput("d_valid",  16'(dValid),  16'(expBeat));
    checkOutput("d_out",    16'(dOut),    16'(expBeat && d));
    checkOutput("done",     16'(done),    16'(mDone));
    checkOutput("pass_cnt", 16'(passCnt), 16'(mPassCnt));
    checkOutput("err",      16'(err),     16'(mErr));
    if (dValid === 1'b1) strobes++;
    if (done === 1'b1) begin
      sawDone   = 1'b1;
      doneCycle = cycleNum;
    end
    if (err === 1'b1) sawErr = 1'b1;

    mDone = 1'b0;
    if (!mActive) begin
      if (st) begin
        mErr = 1'b0;
        if (en == 16'd0) begin
          mDone    = 1'b1;
          mPassCnt = mPassCnt + 8'd1;
        end else begin
          mChans.delete();
          for (int i = 0; i < 16; i++) if (en[i]) mChans.push_back(i);
          mActive = 1'b1;
          mGap    = 1;
        end
      end
    end else if (mGap > 0) begin
      mGap--;
      if (mGap == 0) begin
        if (mChans.size() == 0) begin
          mActive  = 1'b0;
          mDone    = 1'b1;
          mPassCnt = mPassCnt + 8'd1;
        end else begin
          mSel       = 4'(mChans[0]);
          mBeatsLeft = BURST;
          mStall     = 0;
        end
      end
    end else if (expBeat) begin
      mStall = 0;
      mBeatsLeft--;
      if (mBeatsLeft == 0) finishChannel();
    end else begin
`ifdef DEMUX_SCHED_TIMEOUT_EN
      mStall++;
      if (mStall == TMO) begin
        mErr = 1'b1;
        finishChannel();
      end
`endif
    end
  endtask

  // Idle cycles with the given input profile until done is observed.
  task automatic runToDone(input string tag, input int budget, input bit randomize,
                           input logic [15:0] rdy);
    int left;
    logic [15:0] r;
    left = budget;
    while (!sawDone && left > 0) begin
      r = rdy;
      if (randomize) begin
        for (int i = 0; i < 16; i++) r[i] = ($urandom_range(0, 9) != 0);
        applyStimulus(1'b0, 16'h0, ($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)), r);
      end else begin
        applyStimulus(1'b0, 16'h0, 1'b1, 1'($urandom_range(0, 1)), r);
      end
      left--;
    end
    checkOutput(tag, 16'(sawDone), 16'd1);
  endtask

  task automatic clearTrack();
    strobes   = 0;
    sawDone   = 1'b0;
    sawErr    = 1'b0;
    doneCycle = -1;
  endtask

  // Asynchronous reset asserted between edges; outputs must drop at once.
  task automatic pulseReset(input string tag);
    @(negedge clk);
    start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput({tag, "_sel"},      16'(sel),     16'd0);
    checkOutput({tag, "_busy"},     16'(busy),    16'd0);
    checkOutput({tag, "_done"},     16'(done),    16'd0);
    checkOutput({tag, "_in_ready"}, 16'(inReady), 16'd0);
    checkOutput({tag, "_d_valid"},  16'(dValid),  16'd0);
    checkOutput({tag, "_d_out"},    16'(dOut),    16'd0);
    checkOutput({tag, "_pass_cnt"}, 16'(passCnt), 16'd0);
    checkOutput({tag, "_err"},      16'(err),     16'd0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    int startCycle;
    int passBefore;
    logic [15:0] rdy;
    logic [15:0] m;

    rst       = 1'b0;
    start     = 1'b0;
    chanEn    = 16'h0;
    inValid   = 1'b1;
    inData    = 1'b1;
    destReady = 16'hFFFF;
    cycleNum  = 0;
    modelReset();
    clearTrack();

    // Reset state
    pulseReset("reset");

    // Full mask, no stall: 64 strobes, done 97 cycles after start
    clearTrack();
    applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF);
    startCycle = cycleNum;
    runToDone("full_pass_done", 200, 1'b0, 16'hFFFF);
    checkOutput("full_strobes", 16'(strobes), 16'd64);
    checkOutput("full_done_latency", 16'(doneCycle - startCycle), 16'd97);
    checkOutput("full_pass_cnt", 16'(passCnt), 16'd1);

    // Sparse mask: only 0, 4, 15 visited, random data and valid
    clearTrack();
    applyStimulus(1'b1, 16'h8011, 1'b0, 1'b0, 16'hFFFF);
    runToDone("sparse_done", 400, 1'b1, 16'hFFFF);
    checkOutput("sparse_strobes", 16'(strobes), 16'd12);

    // Backpressure on channel 4 for 5 cycles after two beats
    clearTrack();
    applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, 16'hFFFF);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'hFFFF);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'hFFFF);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'hFFFF);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 16'h0, 1'b1, 1'($urandom_range(0, 1)), 16'hFFEF);
    checkOutput("bp_stall_strobes", 16'(strobes), 16'd2);
    runToDone("bp_done", 50, 1'b0, 16'hFFFF);
    checkOutput("bp_strobes", 16'(strobes), 16'd4);

    // Empty mask: done on the next cycle, never busy
    clearTrack();
    applyStimulus(1'b1, 16'h0000, 1'b1, 1'b1, 16'hFFFF);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'hFFFF);
    checkOutput("empty_done_next", 16'(sawDone), 16'd1);

    // Start while busy is dropped: one pass, one count
    clearTrack();
    passBefore = int'(passCnt);
    applyStimulus(1'b1, 16'h0003, 1'b1, 1'b0, 16'hFFFF);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'hFFFF);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'hFFFF);
    applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF);
    runToDone("busy_start_done", 60, 1'b0, 16'hFFFF);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'hFFFF);
    checkOutput("busy_start_strobes", 16'(strobes), 16'd8);
    checkOutput("busy_start_count", 16'(passCnt), 16'(passBefore + 1));

    // Reset in the middle of channel 3's burst, then restart
    clearTrack();
    applyStimulus(1'b1, 16'h0018, 1'b1, 1'b0, 16'hFFFF);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'hFFFF);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'hFFFF);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'hFFFF);
    pulseReset("mid_reset");
    clearTrack();
    applyStimulus(1'b1, 16'h0018, 1'b1, 1'b0, 16'hFFFF);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'hFFFF);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'hFFFF);
    checkOutput("restart_sel", 16'(sel), 16'd3);
    runToDone("restart_done", 60, 1'b0, 16'hFFFF);
    checkOutput("restart_strobes", 16'(strobes), 16'd8);

`ifdef DEMUX_SCHED_TIMEOUT_EN
    // Channel 2 never ready: watchdog skips it and flags err
    clearTrack();
    applyStimulus(1'b1, 16'h0006, 1'b1, 1'b0, 16'hFFFF);
    runToDone("timeout_done", 200, 1'b0, 16'hFFFB);
    checkOutput("timeout_strobes", 16'(strobes), 16'd4);
    checkOutput("timeout_err", 16'(sawErr), 16'd1);
`endif

    // Random passes with random masks, backpressure and stray starts
    for (int p = 0; p < 8; p++) begin
      clearTrack();
      m = 16'($urandom);
      if (p == 3) m = 16'h0;
      applyStimulus(1'b1, m, 1'b1, 1'b0, 16'hFFFF);
      for (int c = 0; c < 600 && !sawDone; c++) begin
        for (int i = 0; i < 16; i++) rdy[i] = ($urandom_range(0, 9) != 0);
        applyStimulus(($urandom_range(0, 15) == 0), 16'($urandom),
                      ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rdy);
      end
      checkOutput("random_pass_done", 16'(sawDone), 16'd1);
      while (busy === 1'b1 && cycleNum < 60000)
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'hFFFF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/demux_rr_scheduler.md
# demux_rr_scheduler

Sequencer for the 16-way 1-bit demux datapath. On each `start`, it walks every enabled destination channel in ascending order. For each channel it drives the demux select, then forwards a fixed-length burst of input beats under a valid/ready handshake. One full walk is a "pass"; the block pulses `done` at the end of each pass. It sits between a serial source and the demux, owning `S` and gating `D`.

## Interface
Parameters:
- `N_CH`, 16: number of demux outputs; fixed at 16 in this revision.
- `SEL_W`, 4: select width, equal to log2(`N_CH`).
- `BURST_LEN`, 4: beats delivered per channel per pass; range 1..255.
- `CNT_W`, 8: width of the pass counter.
- `TIMEOUT`, 32: stall limit in cycles; used only with the watchdog compiled in.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: one-cycle pulse that begins a pass; ignored while `busy`=1.
- `chan_en`, in, 16: channel enable mask; sampled on an accepted `start`.
- `in_valid`, in, 1: source beat valid.
- `in_data`, in, 1: source beat data.
- `in_ready`, out, 1: beat accepted this cycle when `in_valid` & `in_ready`.
- `dest_ready`, in, 16: per-destination backpressure.
- `sel`, out, 4: demux `S`; registered.
- `d_out`, out, 1: demux `D`.
- `d_valid`, out, 1: beat strobe toward destinations.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at end of pass.
- `pass_cnt`, out, `CNT_W`: completed passes; wraps at 2^`CNT_W`.
- `err`, out, 1: sticky timeout flag; cleared on accepted `start`.

## Operation
- **States:** IDLE, SEEK, XFER, NEXT.
- **IDLE:**
  - `start` with `chan_en`≠0: latch mask into `mask_q`, set `ptr`=0, go to SEEK.
  - `start` with `chan_en`=0: pulse `done`, increment `pass_cnt`, stay in IDLE.
- **SEEK:**
  - Find the lowest set bit of `mask_q` at index ≥ `ptr`.
  - Load it into `sel`, clear `beat_cnt`, go to XFER.
  - A match always exists by construction.
- **XFER:**
  - `in_ready` = `dest_ready[sel]`.
  - A beat occurs when `in_valid` & `dest_ready[sel]`: `d_out`=`in_data`, `d_valid`=1, `beat_cnt`++.
  - The beat that makes `beat_cnt`=`BURST_LEN` moves to NEXT.
- **NEXT:**
  - Clear `mask_q[sel]`, set `ptr`=`sel`+1.
  - If the remaining mask is 0: pulse `done`, increment `pass_cnt`, go to IDLE.
  - Otherwise go to SEEK.
- **Outside XFER:** `in_ready`=0, `d_valid`=0, `d_out`=0. `sel` holds its last value.
- **Mask changes:** changing `chan_en` during a pass has no effect.
- **`start` while busy:** dropped, no side effects.

## Timing
- **Reset values:** state IDLE; `sel`=0, `pass_cnt`=0, `err`=0, `busy`=0, `done`=0, `in_ready`=0, `d_valid`=0, `d_out`=0.
- **Start latency:** `start` at cycle T → SEEK at T+1 → XFER with `sel` valid at T+2. The first beat can be accepted at T+2.
- **Handshake path:** `d_out`, `d_valid` and `in_ready` are combinational from `in_valid`, `in_data` and `dest_ready` in XFER. Zero-latency pass-through.
- **Channel switch cost:** 2 idle cycles (NEXT, SEEK).
- **Best-case pass length:** k enabled channels give a best-case pass of 1 + k·(`BURST_LEN`+2) cycles, start to `done`.
- **`done` timing:** asserted in the cycle after the last NEXT, i.e. while registered state returns to IDLE. `busy` is already 0 in that cycle.
- **Reset mid-burst:** outputs return to reset values immediately. The partial burst is lost and not resumed.

## Configuration
- Macro `DEMUX_SCHED_TIMEOUT_EN`.
- **Defined:**
  - A stall counter runs in XFER and clears on every beat.
  - When it reaches `TIMEOUT` with no beat, set `err`=1 and go to NEXT, skipping the rest of that channel's burst.
- **Undefined:** no stall counter is built, `err` is tied 0, and XFER waits indefinitely.

## Structure
- **Package `demux_sched_pkg`:**
  - `state_t` enum (IDLE, SEEK, XFER, NEXT).
  - Constants `N_CH`=16 and `SEL_W`=4.
- **Sub-module `next_chan_finder`:** combinational. Inputs mask[15:0] and ptr[3:0]; outputs idx[3:0] and found. Lowest set bit at index ≥ ptr.

## Test plan
- **Full mask, no stall:** `chan_en`=16'hFFFF, `in_valid`=1, `dest_ready`=all 1 → `sel` steps 0..15, 4 beats each, 64 `d_valid` strobes. `done` 1 + 16·6 = 97 cycles after `start`; `pass_cnt`=1.
- **Sparse mask:** `chan_en`=16'h8011 → only `sel`=0, 4 then 15 are visited. `d_out` matches the `in_data` pattern.
- **Backpressure:** `dest_ready[4]` low for 5 cycles mid-burst → `in_ready`=0 and no beat during the stall. The burst completes with exactly 4 beats.
- **Empty mask and busy start:**
  - `start` with `chan_en`=0 → `done` next cycle, `busy` never asserts.
  - `start` while busy → ignored; `pass_cnt` increments once.
- **Reset mid-burst:** `rst` pulsed during XFER on channel 3 → all outputs at reset values. A fresh `start` begins again at the lowest enabled channel.
- **Timeout (macro defined, `TIMEOUT`=32):** `dest_ready[2]`=0 permanently → after 32 stalled cycles `err`=1, channel 2 is skipped and the pass completes.
